// File: rtl/regfile_wb_buffer.sv
// Writeback buffer in front of the regfile write port: queues (rd, data) results, drains them
// in order one per cycle, and forwards the youngest pending value for two read addresses.
module regfile_wb_buffer #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]   wb_rd_i,
    input  logic [DATA_WIDTH-1:0]      wb_data_i,
    input  logic                       drain_en_i,
    output logic                       WE3_o,
    output logic [ADDRESS_WIDTH-1:0]   AD3_o,
    output logic [DATA_WIDTH-1:0]      WD3_o,
    input  logic [ADDRESS_WIDTH-1:0]   AD1_i,
    input  logic [ADDRESS_WIDTH-1:0]   AD2_i,
    output logic                       fwd1_hit_o,
    output logic [DATA_WIDTH-1:0]      fwd1_data_o,
    output logic                       fwd2_hit_o,
    output logic [DATA_WIDTH-1:0]      fwd2_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] rd_mem_q   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] rd_mem_d   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem_d [DEPTH];

    logic push;
    logic pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign wb_ready_o = !full_o;
    assign count_o    = count_q;

    // Writes to x0 complete the handshake but are dropped here.
    assign push  = wb_valid_i && !full_o && (wb_rd_i != '0);
    assign pop   = !empty_o && drain_en_i;
    assign WE3_o = pop;
    assign AD3_o = empty_o ? '0 : rd_mem_q[head_q];
    assign WD3_o = empty_o ? '0 : data_mem_q[head_q];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            rd_mem_d[tail_q]   = wb_rd_i;
            data_mem_d[tail_q] = wb_data_i;
            tail_d             = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_hit_o  = 1'b0;
        fwd2_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((AD1_i != '0) && (rd_mem_q[head_q + PW'(i)] == AD1_i)) begin
                    fwd1_hit_o  = 1'b1;
                    fwd1_data_o = data_mem_q[head_q + PW'(i)];
                end
                if ((AD2_i != '0) && (rd_mem_q[head_q + PW'(i)] == AD2_i)) begin
                    fwd2_hit_o  = 1'b1;
                    fwd2_data_o = data_mem_q[head_q + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never read while unoccupied, so it carries no reset.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer: drain order, full/hold, forwarding, x0 drop, async reset.
module tb_regfile_wb_buffer;

    logic        clk;
    logic        rst_n;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        drain_en_i;
    logic        WE3_o;
    logic [4:0]  AD3_o;
    logic [31:0] WD3_o;
    logic [4:0]  AD1_i;
    logic [4:0]  AD2_i;
    logic        fwd1_hit_o;
    logic [31:0] fwd1_data_o;
    logic        fwd2_hit_o;
    logic [31:0] fwd2_data_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_buffer #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .drain_en_i(drain_en_i),
        .WE3_o(WE3_o), .AD3_o(AD3_o), .WD3_o(WD3_o),
        .AD1_i(AD1_i), .AD2_i(AD2_i),
        .fwd1_hit_o(fwd1_hit_o), .fwd1_data_o(fwd1_data_o),
        .fwd2_hit_o(fwd2_hit_o), .fwd2_data_o(fwd2_data_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        wb_valid_i = 1'b0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
        drain_en_i = 1'b0;
        AD1_i      = 5'd5;
        AD2_i      = '0;
        #2;
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_ready", 32'(wb_ready_o), 1);
        check("rst_we3", 32'(WE3_o), 0);
        check("rst_fwd1_hit", 32'(fwd1_hit_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single result, drain enabled: no bypass, appears next cycle
        drain_en_i = 1'b1;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        wb_data_i  = 32'hDEADBEEF;
        #1;
        check("t2_no_bypass", 32'(WE3_o), 0);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("t2_we3", 32'(WE3_o), 1);
        check("t2_ad3", 32'(AD3_o), 5);
        check("t2_wd3", WD3_o, 32'hDEADBEEF);
        check("t2_count", 32'(count_o), 1);
        tick();
        check("t2_empty", 32'(empty_o), 1);
        check("t2_we3_off", 32'(WE3_o), 0);

        // fill to full, hold the fifth request, then drain with wrap
        drain_en_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid_i = 1'b1;
            wb_rd_i    = 5'(i);
            wb_data_i  = 32'h100 + 32'(i);
            tick();
        end
        wb_rd_i   = 5'd5;
        wb_data_i = 32'h105;
        #1;
        check("t3_full", 32'(full_o), 1);
        check("t3_ready", 32'(wb_ready_o), 0);
        check("t3_count4", 32'(count_o), 4);
        tick();
        check("t3_held_count", 32'(count_o), 4);
        drain_en_i = 1'b1;
        #1;
        check("t3_ad3_1", 32'(AD3_o), 1);
        check("t3_we3", 32'(WE3_o), 1);
        tick();
        check("t3_count_after_first", 32'(count_o), 3);
        check("t3_ready_again", 32'(wb_ready_o), 1);
        check("t3_ad3_2", 32'(AD3_o), 2);
        tick();
        wb_valid_i = 1'b0;
        check("t3_both_count", 32'(count_o), 3);
        check("t3_ad3_3", 32'(AD3_o), 3);
        tick();
        check("t3_ad3_4", 32'(AD3_o), 4);
        check("t3_count2", 32'(count_o), 2);
        tick();
        check("t3_ad3_5", 32'(AD3_o), 5);
        check("t3_wd3_5", WD3_o, 32'h105);
        check("t3_count1", 32'(count_o), 1);
        tick();
        check("t3_empty", 32'(empty_o), 1);
        check("t3_ad3_empty", 32'(AD3_o), 0);
        check("t3_wd3_empty", WD3_o, 0);

        // youngest-match forwarding; an in-flight enqueue is not yet visible
        drain_en_i = 1'b0;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd7;
        wb_data_i  = 32'd1;
        tick();
        wb_data_i = 32'd2;
        tick();
        wb_valid_i = 1'b0;
        AD1_i      = 5'd7;
        AD2_i      = 5'd0;
        #1;
        check("t4_fwd1_hit", 32'(fwd1_hit_o), 1);
        check("t4_fwd1_data", fwd1_data_o, 2);
        check("t4_fwd2_hit_x0", 32'(fwd2_hit_o), 0);
        check("t4_fwd2_data_x0", fwd2_data_o, 0);
        AD2_i      = 5'd9;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd9;
        wb_data_i  = 32'h99;
        #1;
        check("t4_inflight_miss", 32'(fwd2_hit_o), 0);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("t4_fwd2_hit", 32'(fwd2_hit_o), 1);
        check("t4_fwd2_data", fwd2_data_o, 32'h99);

        // x0 write: accepted but dropped
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd0;
        wb_data_i  = 32'h55;
        #1;
        check("t5_ready", 32'(wb_ready_o), 1);
        tick();
        wb_valid_i = 1'b0;
        check("t5_count", 32'(count_o), 3);
        drain_en_i = 1'b1;
        #1;
        check("t5_head_fwd", 32'(fwd1_hit_o), 1);
        check("t5_d0_ad3", 32'(AD3_o), 7);
        check("t5_d0_wd3", WD3_o, 1);
        tick();
        check("t5_d1_ad3", 32'(AD3_o), 7);
        check("t5_d1_wd3", WD3_o, 2);
        tick();
        check("t5_d2_ad3", 32'(AD3_o), 9);
        tick();
        check("t5_no_x0_write", 32'(WE3_o), 0);
        check("t5_empty", 32'(empty_o), 1);

        // async reset mid-cycle discards pending entries
        drain_en_i = 1'b0;
        for (int i = 10; i <= 12; i++) begin
            wb_valid_i = 1'b1;
            wb_rd_i    = 5'(i);
            wb_data_i  = 32'(i);
            tick();
        end
        wb_valid_i = 1'b0;
        AD1_i      = 5'd10;
        #1;
        check("t6_count3", 32'(count_o), 3);
        check("t6_pre_fwd", 32'(fwd1_hit_o), 1);
        #1;
        rst_n      = 1'b0;
        drain_en_i = 1'b1;
        #1;
        check("t6_count", 32'(count_o), 0);
        check("t6_empty", 32'(empty_o), 1);
        check("t6_we3", 32'(WE3_o), 0);
        check("t6_ad3", 32'(AD3_o), 0);
        check("t6_wd3", WD3_o, 0);
        check("t6_fwd1", 32'(fwd1_hit_o), 0);
        check("t6_fwd1_data", fwd1_data_o, 0);
        check("t6_ready", 32'(wb_ready_o), 1);
        check("t6_full", 32'(full_o), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_write_after", 32'(WE3_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
